// File: rtl/alu_pipe_nb_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the pipelined ALU: opcode encodings, bit positions
//   of the status flags inside o_flags, and small WIDTH-independent helpers
//   used by the combinational core.
//   Opcodes 0-7 keep the legacy 3-bit {mode, select} encoding. Opcodes 8-13
//   add the carry-chained, shift and pass operations. Opcodes 14-15 are
//   reserved.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] OP_NOT   = 4'd0;
    localparam logic [3:0] OP_AND   = 4'd1;
    localparam logic [3:0] OP_XOR   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_DEC   = 4'd4;
    localparam logic [3:0] OP_ADD   = 4'd5;
    localparam logic [3:0] OP_SUB   = 4'd6;
    localparam logic [3:0] OP_INC   = 4'd7;
    localparam logic [3:0] OP_ADC   = 4'd8;
    localparam logic [3:0] OP_SBB   = 4'd9;
    localparam logic [3:0] OP_SHL   = 4'd10;
    localparam logic [3:0] OP_SHR   = 4'd11;
    localparam logic [3:0] OP_SAR   = 4'd12;
    localparam logic [3:0] OP_PASSB = 4'd13;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Only these operations own the persistent carry; every other opcode
    // leaves the carry chain untouched.
    function automatic logic writes_carry(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC) ||
               (op == OP_SBB) || (op == OP_SHL) || (op == OP_SHR) ||
               (op == OP_SAR);
    endfunction

    // Signed overflow of an addition: operands share a sign and the result
    // sign differs from it.
    function automatic logic add_ovf(input logic a_s, input logic b_s,
                                     input logic r_s);
        return (a_s == b_s) && (r_s != a_s);
    endfunction

    // Signed overflow of a subtraction: operand signs differ and the result
    // sign differs from the minuend.
    function automatic logic sub_ovf(input logic a_s, input logic b_s,
                                     input logic r_s);
        return (a_s != b_s) && (r_s != a_s);
    endfunction

endpackage

// File: rtl/alu_pipe_nb_if.sv
// ---------------------------------------------------------------------------
// alu_pipe_nb_if
//   Operation and result handshake bundle for alu_pipe_nb.
//   Upstream side : i_valid, o_ready, i_op, i_dataA, i_dataB
//   Downstream side: o_valid, i_ready, o_data, o_flags ({N,Z,C,V})
//   Modport slave is the ALU's view. Modport master is the view of the
//   surrounding logic, which drives operations and accepts results.
// ---------------------------------------------------------------------------
interface alu_pipe_nb_if #(
    parameter int WIDTH = 32
);

    logic             i_valid;
    logic             o_ready;
    logic [3:0]       i_op;
    logic [WIDTH-1:0] i_dataA;
    logic [WIDTH-1:0] i_dataB;

    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_data;
    logic [3:0]       o_flags;

    modport slave (
        input  i_valid,
        output o_ready,
        input  i_op,
        input  i_dataA,
        input  i_dataB,
        output o_valid,
        input  i_ready,
        output o_data,
        output o_flags
    );

    modport master (
        output i_valid,
        input  o_ready,
        output i_op,
        output i_dataA,
        output i_dataB,
        input  o_valid,
        output i_ready,
        input  o_data,
        input  o_flags
    );

endinterface

// File: rtl/alu_pipe_nb_core.sv
// ---------------------------------------------------------------------------
// alu_nb_core
//   Purely combinational ALU datapath.
//   Ports:
//     op     in  4      opcode (see alu_pkg)
//     a, b   in  WIDTH  operands
//     c_in   in  1      current persistent carry
//     result out WIDTH  operation result
//     n,z,c,v out 1     status flags for result
//     c_we   out 1      result carry must be written to the carry register
// ---------------------------------------------------------------------------
module alu_nb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] result,
    output logic             n,
    output logic             z,
    output logic             c,
    output logic             v,
    output logic             c_we
);

    localparam int MSB = WIDTH - 1;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             chain_in;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_diff;

    // One adder and one subtractor are shared between the plain and the
    // carry-chained forms. The extra top bit is the carry-out / borrow.
    assign chain_in = ((op == OP_ADC) || (op == OP_SBB)) ? c_in : 1'b0;
    assign add_sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, chain_in};
    assign sub_diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, chain_in};

    always_comb begin
        result = '0;
        c      = c_in;
        v      = 1'b0;
        case (op)
            OP_NOT: result = ~a;
            OP_AND: result = a & b;
            OP_XOR: result = a ^ b;
            OP_OR:  result = a | b;
            OP_DEC: begin
                result = a - ONE;
                v      = sub_ovf(a[MSB], 1'b0, result[MSB]);
            end
            OP_ADD, OP_ADC: begin
                result = add_sum[WIDTH-1:0];
                c      = add_sum[WIDTH];
                v      = add_ovf(a[MSB], b[MSB], result[MSB]);
            end
            OP_SUB, OP_SBB: begin
                result = sub_diff[WIDTH-1:0];
                c      = sub_diff[WIDTH];
                v      = sub_ovf(a[MSB], b[MSB], result[MSB]);
            end
            OP_INC: begin
                result = a + ONE;
                v      = add_ovf(a[MSB], 1'b0, result[MSB]);
            end
            OP_SHL: begin
                result = {a[MSB-1:0], 1'b0};
                c      = a[MSB];
            end
            OP_SHR: begin
                result = {1'b0, a[MSB:1]};
                c      = a[0];
            end
            OP_SAR: begin
                result = {a[MSB], a[MSB:1]};
                c      = a[0];
            end
            OP_PASSB: result = b;
            // Reserved opcodes report a fixed zero result with C cleared;
            // the carry register itself is not written.
            default: begin
                result = '0;
                c      = 1'b0;
            end
        endcase
    end

    assign n    = result[MSB];
    assign z    = (result == '0);
    assign c_we = writes_carry(op);

endmodule

// File: rtl/alu_pipe_nb.sv
// ---------------------------------------------------------------------------
// alu_pipe_nb
//   Two-stage pipelined ALU with valid/ready on both sides and a persistent
//   carry register for multi-word add/subtract chains.
//   Ports:
//     i_clk    in   clock, all state on the rising edge
//     i_rst_n  in   asynchronous active-low reset
//     bus      slave modport of alu_pipe_nb_if (operation in, result out)
//   S1 holds the accepted opcode and operands. S2 holds the registered
//   result and flags. The carry register is updated in step with S2, so
//   chained ops always see the carry of the previous op in program order.
// ---------------------------------------------------------------------------
module alu_pipe_nb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    alu_pipe_nb_if.slave  bus
);

    logic             s1_v;
    logic [3:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    logic             out_v;
    logic [WIDTH-1:0] out_data;
    logic [3:0]       out_flags;
    logic             c_q;

    logic             s2_adv;
    logic             s1_adv;
    logic             in_ready;

    logic [WIDTH-1:0] core_result;
    logic             core_n;
    logic             core_z;
    logic             core_c;
    logic             core_v;
    logic             core_c_we;
    logic [3:0]       flags_next;

    // S2 may load whenever it is empty or its current result leaves this
    // cycle. S1 can take a new op whenever it is empty or is draining into S2.
    // o_ready depends on i_ready but never on i_valid.
    assign s2_adv   = !out_v || bus.i_ready;
    assign s1_adv   = s1_v && s2_adv;
    assign in_ready = !s1_v || s2_adv;

    alu_nb_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op     (s1_op),
        .a      (s1_a),
        .b      (s1_b),
        .c_in   (c_q),
        .result (core_result),
        .n      (core_n),
        .z      (core_z),
        .c      (core_c),
        .v      (core_v),
        .c_we   (core_c_we)
    );

    always_comb begin
        flags_next         = '0;
        flags_next[FLAG_N] = core_n;
        flags_next[FLAG_Z] = core_z;
        flags_next[FLAG_C] = core_c;
        flags_next[FLAG_V] = core_v;
    end

    // Stage 1: capture the operation on every upstream transfer. When S1
    // drains with nothing new arriving it simply goes empty.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_v  <= 1'b0;
            s1_op <= '0;
            s1_a  <= '0;
            s1_b  <= '0;
        end else if (in_ready) begin
            s1_v <= bus.i_valid;
            if (bus.i_valid) begin
                s1_op <= bus.i_op;
                s1_a  <= bus.i_dataA;
                s1_b  <= bus.i_dataB;
            end
        end
    end

    // Stage 2: register the result and flags, and commit the carry on the
    // same edge. A stalled S2 holds its outputs and freezes the carry chain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_v     <= 1'b0;
            out_data  <= '0;
            out_flags <= '0;
            c_q       <= 1'b0;
        end else begin
            if (s2_adv) begin
                out_v <= s1_v;
            end
            if (s1_adv) begin
                out_data  <= core_result;
                out_flags <= flags_next;
                if (core_c_we) begin
                    c_q <= core_c;
                end
            end
        end
    end

    assign bus.o_ready = in_ready;
    assign bus.o_valid = out_v;
    assign bus.o_data  = out_data;
    assign bus.o_flags = out_flags;

endmodule

// File: tb/tb_alu_pipe_nb.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe_nb
//   Self-checking bench for alu_pipe_nb (WIDTH=32). A table of single ops
//   with hand-computed results runs in program order so the carry chain is
//   part of each expectation; hand-written sequences cover back-to-back
//   chaining, backpressure and reset while the pipeline is full.
// ---------------------------------------------------------------------------
module tb_alu_pipe_nb;
    import alu_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] data;
        logic [3:0]   flags;
    } vec_t;

    logic i_clk;
    logic i_rst_n;
    int   checks;
    int   fails;
    int   sent;
    int   recv;
    logic prevStall;
    logic [W-1:0] prevData;
    logic expReady;
    vec_t vecs[$];

    alu_pipe_nb_if #(.WIDTH(W)) bus ();

    alu_pipe_nb #(.WIDTH(W)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    // Free-running clock, period 10.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Single comparison point: every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [W-1:0] act,
                               input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Hold reset for two cycles, confirm the reset state, release at a
    // falling edge.
    task automatic doReset();
        i_rst_n     = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        bus.i_op    = '0;
        bus.i_dataA = '0;
        bus.i_dataB = '0;
        repeat (2) @(negedge i_clk);
        checkOutput("rst_o_valid", {31'b0, bus.o_valid}, 32'd0);
        checkOutput("rst_o_data", bus.o_data, 32'd0);
        checkOutput("rst_o_flags", {28'b0, bus.o_flags}, 32'd0);
        i_rst_n = 1'b1;
        #1;
        checkOutput("rst_o_ready", {31'b0, bus.o_ready}, 32'd1);
    endtask

    // Issue one op into an idle pipeline and check its result two edges on.
    task automatic applyStimulus(input string name, input vec_t vr);
        @(negedge i_clk);
        bus.i_valid = 1'b1;
        bus.i_ready = 1'b1;
        bus.i_op    = vr.op;
        bus.i_dataA = vr.a;
        bus.i_dataB = vr.b;
        #1;
        checkOutput({name, "_ready"}, {31'b0, bus.o_ready}, 32'd1);
        @(negedge i_clk);
        bus.i_valid = 1'b0;
        @(negedge i_clk);
        #1;
        checkOutput({name, "_valid"}, {31'b0, bus.o_valid}, 32'd1);
        checkOutput({name, "_data"}, bus.o_data, vr.data);
        checkOutput({name, "_flags"}, {28'b0, bus.o_flags}, {28'b0, vr.flags});
    endtask

    initial begin
        checks = 0;
        fails  = 0;

        // Table of ops in program order; flags are {N,Z,C,V} and the carry
        // column depends on the rows above.
        vecs.push_back('{OP_ADD,   32'hFFFF_FFFF, 32'h1,         32'h0,         4'b0110});
        vecs.push_back('{OP_PASSB, 32'h0,         32'h1234,      32'h1234,      4'b0010});
        vecs.push_back('{OP_ADC,   32'h0,         32'h0,         32'h1,         4'b0000});
        vecs.push_back('{OP_SUB,   32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 4'b0001});
        vecs.push_back('{OP_SBB,   32'h5,         32'h2,         32'h3,         4'b0000});
        vecs.push_back('{OP_NOT,   32'h0F0F_0F0F, 32'h0,         32'hF0F0_F0F0, 4'b1000});
        vecs.push_back('{OP_AND,   32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 4'b0000});
        vecs.push_back('{OP_XOR,   32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h0,         4'b0100});
        vecs.push_back('{OP_OR,    32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 4'b0000});
        vecs.push_back('{OP_DEC,   32'h8000_0000, 32'h0,         32'h7FFF_FFFF, 4'b0001});
        vecs.push_back('{OP_INC,   32'h7FFF_FFFF, 32'h0,         32'h8000_0000, 4'b1001});
        vecs.push_back('{OP_SUB,   32'h1,         32'h2,         32'hFFFF_FFFF, 4'b1010});
        vecs.push_back('{OP_SBB,   32'h5,         32'h2,         32'h2,         4'b0000});
        vecs.push_back('{OP_SAR,   32'h8000_0001, 32'h0,         32'hC000_0000, 4'b1010});
        vecs.push_back('{OP_SHR,   32'h8000_0001, 32'h0,         32'h4000_0000, 4'b0010});
        vecs.push_back('{4'd15,    32'h5,         32'h7,         32'h0,         4'b0100});
        vecs.push_back('{OP_PASSB, 32'h0,         32'h0,         32'h0,         4'b0110});
        vecs.push_back('{OP_SHL,   32'h8000_0001, 32'h0,         32'h0000_0002, 4'b0010});
        vecs.push_back('{4'd14,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         4'b0100});
        vecs.push_back('{OP_ADC,   32'h7FFF_FFFF, 32'h0,         32'h8000_0000, 4'b1001});
        vecs.push_back('{OP_INC,   32'hFFFF_FFFF, 32'h0,         32'h0,         4'b0100});
        vecs.push_back('{OP_SUB,   32'h0,         32'h1,         32'hFFFF_FFFF, 4'b1010});
        vecs.push_back('{OP_SBB,   32'h0,         32'h0,         32'hFFFF_FFFF, 4'b1010});
        vecs.push_back('{OP_ADC,   32'h0,         32'h0,         32'h1,         4'b0000});

        doReset();
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i]);
        end

        // Back-to-back ADD then ADC: the ADC must see the carry of the ADD
        // even though it enters S2 on the very next edge.
        doReset();
        @(negedge i_clk);
        bus.i_valid = 1'b1;
        bus.i_op    = OP_ADD;
        bus.i_dataA = 32'hFFFF_FFFF;
        bus.i_dataB = 32'h1;
        @(negedge i_clk);
        bus.i_op    = OP_ADC;
        bus.i_dataA = 32'h0;
        bus.i_dataB = 32'h0;
        @(negedge i_clk);
        bus.i_valid = 1'b0;
        #1;
        checkOutput("chain_lo_data", bus.o_data, 32'h0);
        checkOutput("chain_lo_flags", {28'b0, bus.o_flags}, 32'b0110);
        @(negedge i_clk);
        #1;
        checkOutput("chain_hi_valid", {31'b0, bus.o_valid}, 32'd1);
        checkOutput("chain_hi_data", bus.o_data, 32'h1);
        checkOutput("chain_hi_flags", {28'b0, bus.o_flags}, 32'b0000);

        // Backpressure: four INCs on A=0..3 with i_ready low for cycles
        // 2..4. Results must come out as 1..4, hold while stalled, and
        // o_ready must drop only when both stages are occupied.
        doReset();
        sent      = 0;
        recv      = 0;
        prevStall = 1'b0;
        prevData  = '0;
        for (int cyc = 0; cyc < 40 && recv < 4; cyc++) begin
            @(negedge i_clk);
            bus.i_valid = (sent < 4);
            bus.i_op    = OP_INC;
            bus.i_dataA = sent;
            bus.i_dataB = '0;
            bus.i_ready = !(cyc >= 2 && cyc <= 4);
            #1;
            expReady = !((sent - recv) == 2 && !bus.i_ready);
            checkOutput("bp_ready", {31'b0, bus.o_ready}, {31'b0, expReady});
            if (prevStall) begin
                checkOutput("bp_hold_valid", {31'b0, bus.o_valid}, 32'd1);
                checkOutput("bp_hold_data", bus.o_data, prevData);
            end
            if (bus.o_valid && bus.i_ready) begin
                checkOutput("bp_data", bus.o_data, recv + 1);
                recv++;
            end
            prevStall = bus.o_valid && !bus.i_ready;
            prevData  = bus.o_data;
            if (bus.i_valid && bus.o_ready) sent++;
        end
        checkOutput("bp_count", recv, 32'd4);
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        @(negedge i_clk);
        #1;
        checkOutput("bp_no_dup", {31'b0, bus.o_valid}, 32'd0);

        // Reset with both stages full and the carry set: outputs must clear
        // at once, and the ADC afterwards must see a cleared carry.
        doReset();
        @(negedge i_clk);
        bus.i_valid = 1'b1;
        bus.i_ready = 1'b1;
        bus.i_op    = OP_ADD;
        bus.i_dataA = 32'hFFFF_FFFF;
        bus.i_dataB = 32'h1;
        @(negedge i_clk);
        bus.i_ready = 1'b0;
        bus.i_op    = OP_PASSB;
        bus.i_dataB = 32'h9;
        @(negedge i_clk);
        bus.i_dataB = 32'hA;
        #1;
        checkOutput("full_ready", {31'b0, bus.o_ready}, 32'd0);
        checkOutput("full_valid", {31'b0, bus.o_valid}, 32'd1);
        checkOutput("full_flags", {28'b0, bus.o_flags}, 32'b0110);
        #1;
        i_rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", {31'b0, bus.o_valid}, 32'd0);
        checkOutput("midrst_data", bus.o_data, 32'h0);
        checkOutput("midrst_flags", {28'b0, bus.o_flags}, 32'd0);
        checkOutput("midrst_ready", {31'b0, bus.o_ready}, 32'd1);
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        applyStimulus("post_rst_adc", '{OP_ADC, 32'h1, 32'h1, 32'h2, 4'b0000});

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/alu_pipe_nb.md
# alu_pipe_nb

Parametrised, two-stage pipelined ALU with a valid/ready handshake on both sides, per-result status flags and a persistent carry flag that lets add-with-carry and subtract-with-borrow be chained for multi-word arithmetic. It is the next-generation datapath ALU. It keeps the existing 3-bit {mode, select} operation encoding as opcodes 0–7 and adds carry-chained, shift and pass operations. It sits between an operand-fetch stage and a writeback stage, so either side may stall it.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 2)
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  upstream operation valid
- o_ready  out  1  block can accept an operation this cycle
- i_op  in  4  opcode (see Operation)
- i_dataA  in  WIDTH  operand A
- i_dataB  in  WIDTH  operand B
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts result this cycle
- o_data  out  WIDTH  result
- o_flags  out  4  {N, Z, C, V} for o_data

## Operation
- Opcodes: 0 ~A; 1 A&B; 2 A^B; 3 A|B; 4 A−1; 5 A+B; 6 A−B; 7 A+1; 8 A+B+C; 9 A−B−C; 10 A<<1; 11 A>>1 logical; 12 A>>>1 arithmetic; 13 pass B; 14, 15 reserved.
- Opcode 0 is bitwise complement, not negation.
- Reserved opcodes produce o_data=0 and flags {0,1,0,0}. They leave C unchanged.
- All arithmetic is modulo 2^WIDTH. Operands are unsigned for C and two's-complement for V and N.
- For ops 5 and 8, C = carry-out of bit WIDTH−1.
- For ops 6 and 9, C = borrow, which is 1 when A < B (+C_in for op 9) unsigned.
- For ops 10–12, C = the bit shifted out.
- V is signed overflow for ops 4–9 and 0 for all other ops.
- N = o_data[WIDTH−1]. Z = (o_data == 0).
- Carry register `c_q` is updated only by ops 5, 6, 8, 9, 10, 11 and 12. All other ops report o_flags.C = current c_q and leave it unchanged.
- Ops 8 and 9 read c_q as it stands after every earlier accepted operation, in program order.

## Timing
- Stage 1 (S1) registers the opcode and operands on each accepted transfer.
- Stage 2 (S2) computes from the S1 registers. It registers o_data and o_flags and updates c_q on the same edge.
- An upstream transfer occurs when i_valid && o_ready. A downstream transfer occurs when o_valid && i_ready.
- Latency is 2 cycles: an operation accepted at edge k is presented on o_valid after edge k+1. Throughput is 1 op/cycle with no bubbles while i_ready=1.
- Stall conditions:
  - s2_adv = !o_valid || i_ready
  - s1_adv = s1_v && s2_adv
  - o_ready = !s1_v || s2_adv
- o_ready is combinational from i_ready. There is no combinational path from i_valid to o_ready.
- While o_valid && !i_ready, o_data and o_flags hold stable. No operation is dropped or duplicated.
- c_q changes only when S2 loads. A stalled S2 freezes the carry chain.
- Simultaneous accept and emit in the same cycle is legal and must be supported with full throughput.
- Reset values (immediate on i_rst_n low, mid-operation included):
  - s1_v=0, o_valid=0, o_data=0, o_flags=0, c_q=0
  - o_ready=1 in the first cycle after reset release
  - In-flight operations are discarded.

## Structure
- Package `alu_pkg`:
  - opcode localparams (OP_NOT … OP_PASSB)
  - flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0)
  - WIDTH-independent helpers
- Sub-module `alu_nb_core`: purely combinational, parametrised by WIDTH. It takes (op, A, B, c_in) and returns (result, N, Z, C, V, c_we). The top level owns the S1/S2 registers, handshake and c_q.

## Test plan
- Reset then single ADD: 32'hFFFF_FFFF + 32'h1, i_ready=1 → 2 cycles later o_data=0, flags {0,1,1,0}, c_q=1.
- 64-bit chain: ADD 32'hFFFF_FFFF+1 then ADC 0+0 back-to-back → second result 32'h1, flags {0,0,0,0}.
- Signed overflow: SUB 32'h8000_0000 − 1 → o_data=32'h7FFF_FFFF, flags {0,0,0,1}. Then SBB 5−2 with c_q=0 → 3.
- Backpressure: stream 4 INC ops on A=0..3 with i_ready low for 3 cycles mid-stream → outputs 1,2,3,4 in order, none dropped or repeated, o_data stable while stalled, o_ready low once both stages are full.
- Shifts and reserved:
  - SAR 32'h8000_0001 → 32'hC000_0000, C=1
  - SHR same operand → 32'h4000_0000, C=1
  - op 15 → o_data=0, Z=1, c_q unchanged
- Reset mid-stream: assert i_rst_n low with both stages full and c_q=1 → o_valid=0, c_q=0 immediately. The first op after release is ADC 1+1, which gives 2.
